run_ctrl: RTL and testbench

- Run sequencer between the test host and the processor core.
- Owns the req/done handshake and holds the core in reset between runs.
- Gives the core a clock enable, counts run cycles and enforces a watchdog timeout.
- Arbitrates the single data-memory write port: the host preloads memory while the core is idle, and the core owns the port while it runs.

---
 rtl/run_ctrl_if.sv | 51 +++++
 rtl/run_ctrl.sv | 127 ++++++++++++
 tb/tb_run_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_if.sv
// Host/core/memory signal bundle for the run sequencer.
// With RUN_CTRL_STEP_EN defined the bundle also carries step_mode/step.
interface run_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int CW = 16
);
    logic          req;
    logic          done;
    logic          busy;
    logic          timeout;
    logic [CW-1:0] cyc_cnt;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_dat;
    logic          core_rst;
    logic          core_en;
    logic          core_halt;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_dat;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
`ifdef RUN_CTRL_STEP_EN
    logic          step_mode;
    logic          step;
`endif

    modport slave (
`ifdef RUN_CTRL_STEP_EN
        input  step_mode, step,
`endif
        input  req, ld_en, ld_addr, ld_dat,
        input  core_halt, core_we, core_addr, core_dat,
        output done, busy, timeout, cyc_cnt,
        output core_rst, core_en,
        output mem_we, mem_addr, mem_din
    );

    modport master (
`ifdef RUN_CTRL_STEP_EN
        output step_mode, step,
`endif
        output req, ld_en, ld_addr, ld_dat,
        output core_halt, core_we, core_addr, core_dat,
        input  done, busy, timeout, cyc_cnt,
        input  core_rst, core_en,
        input  mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/run_ctrl.sv
// Run sequencer: req/done handshake, core reset/enable, cycle count, watchdog, memory-port arbitration.
// Optional single-step core enable is compiled in with RUN_CTRL_STEP_EN.
//
// state  | meaning
// IDLE   | core held in reset, host owns memory port
// CLR    | core reset held RST_CYC cycles before the run
// RUN    | core enabled, core owns memory port
// DONE   | run finished, core state kept, waiting for req low
module run_ctrl #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int CW      = 16,
    parameter int RST_CYC = 2,
    parameter int MAX_CYC = 4096
) (
    input logic         clk,
    input logic         reset,
    run_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_t;

    localparam int            RCW     = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);
    localparam logic [CW-1:0]  WD_LAST  = CW'(MAX_CYC - 1);
    localparam logic [CW-1:0]  CNT_SAT  = '1;

    state_t         state, state_nx;
    logic [RCW-1:0] rst_cnt;
    logic [CW-1:0]  cyc_cnt;
    logic           timeout;
    logic           step_ok;
    logic           run_en;
    logic           wd_hit;
    logic           done_c, busy_c, core_rst_c;
    logic           mem_we_c;
    logic [AW-1:0]  mem_addr_c;
    logic [DW-1:0]  mem_din_c;

`ifdef RUN_CTRL_STEP_EN
    // A step is one enabled cycle per rising edge of step.
    logic step_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) step_q <= 1'b0;
        else       step_q <= bus.step;
    end
    assign step_ok = !bus.step_mode || (bus.step && !step_q);
`else
    assign step_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        run_en     = 1'b0;
        wd_hit     = 1'b0;
        done_c     = 1'b0;
        busy_c     = 1'b0;
        core_rst_c = 1'b0;
        mem_we_c   = bus.ld_en;
        mem_addr_c = bus.ld_addr;
        mem_din_c  = bus.ld_dat;
        case (state)
            S_IDLE: begin
                core_rst_c = 1'b1;
                if (bus.req) state_nx = S_CLR;
            end
            S_CLR: begin
                core_rst_c = 1'b1;
                busy_c     = 1'b1;
                mem_we_c   = 1'b0;
                if (rst_cnt == RST_LAST) state_nx = S_RUN;
            end
            S_RUN: begin
                busy_c     = 1'b1;
                run_en     = step_ok;
                mem_we_c   = bus.core_we;
                mem_addr_c = bus.core_addr;
                mem_din_c  = bus.core_dat;
                // Halt takes priority over the watchdog in the same cycle.
                if (run_en) begin
                    if (bus.core_halt) begin
                        state_nx = S_DONE;
                    end else if (cyc_cnt == WD_LAST) begin
                        state_nx = S_DONE;
                        wd_hit   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_c = 1'b1;
                if (!bus.req) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt <= '0;
            cyc_cnt <= '0;
            timeout <= 1'b0;
        end else if (state == S_IDLE && bus.req) begin
            rst_cnt <= '0;
            cyc_cnt <= '0;
            timeout <= 1'b0;
        end else if (state == S_CLR) begin
            rst_cnt <= rst_cnt + RCW'(1);
        end else if (run_en) begin
            if (cyc_cnt != CNT_SAT) cyc_cnt <= cyc_cnt + CW'(1);
            if (wd_hit) timeout <= 1'b1;
        end
    end

    assign bus.done     = done_c;
    assign bus.busy     = busy_c;
    assign bus.timeout  = timeout;
    assign bus.cyc_cnt  = cyc_cnt;
    assign bus.core_rst = core_rst_c;
    assign bus.core_en  = run_en;
    assign bus.mem_we   = mem_we_c;
    assign bus.mem_addr = mem_addr_c;
    assign bus.mem_din  = mem_din_c;
endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: run results go through a scoreboard checked when done rises,
// other behaviour is checked directly at the falling clock edge.
module tb_run_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    run_ctrl_if #(.AW(8), .DW(8), .CW(16)) bus();

    run_ctrl #(.AW(8), .DW(8), .CW(16), .RST_CYC(2), .MAX_CYC(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] cnt;
        logic        to;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic done_d = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each rising done retires one expected run result.
    always @(negedge clk) begin
        if (bus.done === 1'b1 && done_d !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected done: cyc_cnt=%0d with no run expected", bus.cyc_cnt);
            end else begin
                mon_e = sb.pop_front();
                chk("run cyc_cnt", bus.cyc_cnt, mon_e.cnt);
                chk("run timeout", bus.timeout, mon_e.to);
            end
        end
        done_d <= bus.done;
    end

    // Starts a run and drives it to DONE; halt_at=0 means the core never halts.
    task automatic run(input int halt_at, input logic [15:0] exp_cnt, input logic exp_to,
                       input logic mem_test);
        int  pre;
        int  n;
        bit  fin;
        sb.push_back('{exp_cnt, exp_to});
        @(negedge clk);
        bus.req = 1'b1;
        pre = 0;
        n   = 0;
        fin = 0;
        for (int k = 0; k < 100 && !fin; k++) begin
            @(negedge clk);
            if (bus.done) begin
                fin = 1;
            end else if (!bus.core_en) begin
                pre++;
                chk("clr core_rst", bus.core_rst, 1);
                chk("clr busy", bus.busy, 1);
                chk("clr cyc_cnt cleared", bus.cyc_cnt, 0);
                chk("clr timeout cleared", bus.timeout, 0);
                if (mem_test) begin
                    bus.ld_en = 1'b1; bus.ld_addr = 8'h10; bus.ld_dat = 8'hA5;
                    #1 chk("clr ld_en blocked", bus.mem_we, 0);
                    bus.ld_en = 1'b0;
                end
            end else begin
                n++;
                chk("run cyc_cnt progress", bus.cyc_cnt, n - 1);
                chk("run core_rst low", bus.core_rst, 0);
                if (mem_test && n == 2) begin
                    bus.ld_en = 1'b1; bus.ld_addr = 8'h10; bus.ld_dat = 8'hA5;
                    bus.core_we = 1'b0;
                    #1 chk("run ld_en dropped", bus.mem_we, 0);
                    bus.core_we = 1'b1; bus.core_addr = 8'h22; bus.core_dat = 8'h5A;
                    #1;
                    chk("run mem_we core", bus.mem_we, 1);
                    chk("run mem_addr core", bus.mem_addr, 8'h22);
                    chk("run mem_din core", bus.mem_din, 8'h5A);
                    bus.core_we = 1'b0;
                    bus.ld_en   = 1'b0;
                end
                bus.core_halt = (n == halt_at);
            end
        end
        bus.core_halt = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL run done wait: no done within 100 cycles, required done=1");
        end
        chk("clr cycle count", pre, 2);
        chk("enabled cycle count", n, exp_cnt);
    endtask

    initial begin
        int bad;
        int n;
        reset         = 1'b1;
        bus.req       = 1'b0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_dat    = '0;
        bus.core_halt = 1'b0;
        bus.core_we   = 1'b0;
        bus.core_addr = '0;
        bus.core_dat  = '0;
`ifdef RUN_CTRL_STEP_EN
        bus.step_mode = 1'b0;
        bus.step      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset done", bus.done, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset core_rst", bus.core_rst, 1);
        chk("reset core_en", bus.core_en, 0);
        chk("reset cyc_cnt", bus.cyc_cnt, 0);
        chk("reset timeout", bus.timeout, 0);
        reset = 1'b0;
        @(negedge clk);

        // Host preload in IDLE; core strobe must not reach memory.
        bus.ld_en = 1'b1; bus.ld_addr = 8'h10; bus.ld_dat = 8'hA5;
        bus.core_we = 1'b1; bus.core_addr = 8'h33; bus.core_dat = 8'hCC;
        #1;
        chk("idle mem_we", bus.mem_we, 1);
        chk("idle mem_addr", bus.mem_addr, 8'h10);
        chk("idle mem_din", bus.mem_din, 8'hA5);
        bus.ld_en = 1'b0;
        #1 chk("idle core_we ignored", bus.mem_we, 0);
        bus.core_we = 1'b0;

        // Normal run, halt on 10th enabled cycle.
        run(10, 16'd10, 1'b0, 1'b1);
        chk("done busy low", bus.busy, 0);
        chk("done core_rst low", bus.core_rst, 0);

        // req held high through DONE: no restart.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        chk("req held no restart", bad, 0);
        bus.req = 1'b0;
        @(negedge clk);
        chk("release done", bus.done, 0);
        chk("release core_rst", bus.core_rst, 1);
        chk("release cyc_cnt held", bus.cyc_cnt, 10);

        // Watchdog expiry, then halt coinciding with the watchdog cycle.
        run(0, 16'd16, 1'b1, 1'b0);
        @(negedge clk); bus.req = 1'b0;
        @(negedge clk);
        chk("idle timeout held", bus.timeout, 1);
        run(16, 16'd16, 1'b0, 1'b0);
        @(negedge clk); bus.req = 1'b0;
        @(negedge clk);

        // Reset during RUN on the 5th enabled cycle discards the run.
        bus.req = 1'b1;
        n = 0;
        for (int k = 0; k < 50 && n < 5; k++) begin
            @(negedge clk);
            if (bus.core_en) n++;
        end
        chk("midrun reached cycle 5", n, 5);
        chk("midrun cyc_cnt before reset", bus.cyc_cnt, 4);
        reset   = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        chk("midrun reset busy", bus.busy, 0);
        chk("midrun reset done", bus.done, 0);
        chk("midrun reset core_rst", bus.core_rst, 1);
        chk("midrun reset core_en", bus.core_en, 0);
        chk("midrun reset cyc_cnt", bus.cyc_cnt, 0);
        reset = 1'b0;
        @(negedge clk);

`ifdef RUN_CTRL_STEP_EN
        // Single-step: three step edges, halt on the third stepped cycle.
        begin
            int pulses;
            int stray;
            bit in_run;
            bus.step_mode = 1'b1;
            sb.push_back('{16'd3, 1'b0});
            bus.req = 1'b1;
            in_run = 0;
            for (int k = 0; k < 20 && !in_run; k++) begin
                @(negedge clk);
                if (bus.busy && !bus.core_rst) in_run = 1;
            end
            chk("step reached run", in_run, 1);
            chk("step idle core_en", bus.core_en, 0);
            pulses = 0;
            stray  = 0;
            for (int j = 0; j < 15; j++) begin
                @(negedge clk);
                bus.step = ((j % 5) < 2);
                #1;
                if (bus.core_en) begin
                    pulses++;
                    if ((j % 5) != 0) stray++;
                    if (pulses == 3) bus.core_halt = 1'b1;
                end
            end
            bus.core_halt = 1'b0;
            chk("step pulses", pulses, 3);
            chk("step stray enables", stray, 0);
            chk("step cyc_cnt", bus.cyc_cnt, 3);
            bus.step      = 1'b0;
            bus.step_mode = 1'b0;
            @(negedge clk); bus.req = 1'b0;
            @(negedge clk);
        end
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
